// File: rtl/spi_mem_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_arb_pkg                                                             |
// | Shared types and constants for the SPI memory read arbiter.             |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package spi_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_mem_arbiter_rr_arb2.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_arb2                                                                 |
// | Two-way request picker with a last-grant pointer (round-robin or fixed).|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module rr_arb2
    import spi_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_id,
    output logic       gnt_valid
);

    logic r_last;

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_IF;
        if (req == 2'b11) begin
            gnt_id = RR_EN ? ~r_last : PORT_IF;
        end else if (req[1]) begin
            gnt_id = PORT_D;
        end
    end

    // Reset value makes ifetch the preferred port on the first contested cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= PORT_D;
        end else if (grant_en && gnt_valid) begin
            r_last <= gnt_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_mem_arbiter                                                         |
// | Shares one SPI read engine between ifetch and data ports, with watchdog.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module spi_mem_arbiter
    import spi_arb_pkg::*;
#(
    parameter bit RR_EN          = 1'b1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              mem_abort,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_timeout_last =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t        r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_grant;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
    logic              w_gnt_id, w_gnt_valid, w_grant_en, w_timeout;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({d_req, if_req}),
        .grant_en  (w_grant_en),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_timeout_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        mem_start    = 1'b0;
        mem_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant_en   = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_start    = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // A completion arriving on the timeout cycle takes precedence.
                if (mem_done) begin
                    w_next_state = RESP;
                end else if (w_timeout) begin
                    mem_abort    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_grant    <= PORT_IF;
            r_mem_addr <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant_en) begin
                r_grant    <= w_gnt_id;
                r_mem_addr <= (w_gnt_id == PORT_D) ? d_addr : if_addr;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == WAIT && (mem_done || w_timeout)) begin
                r_err <= !mem_done;
                if (r_grant == PORT_D) begin
                    r_d_rdata <= mem_done ? mem_rdata : '0;
                end else begin
                    r_if_rdata <= mem_done ? mem_rdata : '0;
                end
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign grant_id = r_grant;
    assign mem_addr = r_mem_addr;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_done  = (r_state == RESP) && (r_grant == PORT_IF);
    assign d_done   = (r_state == RESP) && (r_grant == PORT_D);
    assign if_err   = if_done && r_err;
    assign d_err    = d_done && r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_spi_mem_arbiter                                                      |
// | Directed bench: dut_a (round-robin, 256) and dut_b (fixed, 16 cycles).  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n, sel_b;
    logic        if_req, d_req, mem_done;
    logic [15:0] if_addr, d_addr, mem_rdata;

    logic [15:0] a_if_rdata, a_d_rdata, a_mem_addr, b_if_rdata, b_d_rdata, b_mem_addr;
    logic        a_if_done, a_if_err, a_d_done, a_d_err, a_mem_start, a_mem_abort, a_busy, a_grant_id;
    logic        b_if_done, b_if_err, b_d_done, b_d_err, b_mem_start, b_mem_abort, b_busy, b_grant_id;

    logic [15:0] if_rdata, d_rdata, mem_addr;
    logic        if_done, if_err, d_done, d_err, mem_start, mem_abort, busy, grant_id;

    int checks = 0;
    int errors = 0;
    logic        t_st, t_gid;
    logic [15:0] t_ma;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(256)) dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_done(a_if_done), .if_err(a_if_err),
        .d_req(d_req), .d_addr(d_addr), .d_rdata(a_d_rdata), .d_done(a_d_done), .d_err(a_d_err),
        .mem_start(a_mem_start), .mem_addr(a_mem_addr), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_abort(a_mem_abort), .busy(a_busy), .grant_id(a_grant_id)
    );

    spi_mem_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done), .if_err(b_if_err),
        .d_req(d_req), .d_addr(d_addr), .d_rdata(b_d_rdata), .d_done(b_d_done), .d_err(b_d_err),
        .mem_start(b_mem_start), .mem_addr(b_mem_addr), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_abort(b_mem_abort), .busy(b_busy), .grant_id(b_grant_id)
    );

    assign if_rdata  = sel_b ? b_if_rdata  : a_if_rdata;
    assign if_done   = sel_b ? b_if_done   : a_if_done;
    assign if_err    = sel_b ? b_if_err    : a_if_err;
    assign d_rdata   = sel_b ? b_d_rdata   : a_d_rdata;
    assign d_done    = sel_b ? b_d_done    : a_d_done;
    assign d_err     = sel_b ? b_d_err     : a_d_err;
    assign mem_start = sel_b ? b_mem_start : a_mem_start;
    assign mem_addr  = sel_b ? b_mem_addr  : a_mem_addr;
    assign mem_abort = sel_b ? b_mem_abort : a_mem_abort;
    assign busy      = sel_b ? b_busy      : a_busy;
    assign grant_id  = sel_b ? b_grant_id  : a_grant_id;

    task tick;
        @(posedge clk);
        #1;
    endtask

    // The unselected instance is parked in reset so it ignores shared stimulus.
    task apply_reset(input logic which_b);
        sel_b = which_b;
        if_req = 1'b0; d_req = 1'b0; mem_done = 1'b0;
        mem_rdata = 16'h0; if_addr = 16'h0; d_addr = 16'h0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        tick; tick;
        rst_a_n = !which_b;
        rst_b_n = which_b;
    endtask

    // Raises a request, returns what was seen in ISSUE, ends in the first WAIT cycle.
    task issue(input logic port, input logic [15:0] addr,
               output logic st, output logic gid, output logic [15:0] ma);
        if (port) begin d_req = 1'b1; d_addr = addr; end
        else      begin if_req = 1'b1; if_addr = addr; end
        tick;
        st = mem_start; gid = grant_id; ma = mem_addr;
        tick;
    endtask

    task respond(input int n_wait, input logic [15:0] data);
        repeat (n_wait) tick;
        mem_rdata = data; mem_done = 1'b1;
        tick;
        mem_done = 1'b0; mem_rdata = 16'h0;
    endtask

    task test_reset;
        checks++;
        if ({if_rdata, if_done, if_err, d_rdata, d_done, d_err, mem_start, mem_addr,
             mem_abort, busy, grant_id} !== 59'h0) begin
            errors++;
            $display("FAIL reset_outputs dut_b=%0b: if_rdata=%h d_rdata=%h mem_addr=%h busy=%b grant=%b, required all zero",
                     sel_b, if_rdata, d_rdata, mem_addr, busy, grant_id);
        end
    endtask

    task test_single_ifetch;
        int extra_starts, early_done;
        extra_starts = 0; early_done = 0;
        issue(1'b0, 16'h0040, t_st, t_gid, t_ma);
        checks++;
        if ({t_st, t_gid, t_ma} !== {1'b1, 1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL single_issue: start=%b gid=%b addr=%h, required 1 0 0040", t_st, t_gid, t_ma);
        end
        for (int i = 0; i < 19; i++) begin
            if (mem_start) extra_starts++;
            if (if_done || d_done) early_done++;
            tick;
        end
        mem_rdata = 16'hA5C3; mem_done = 1'b1;
        tick;
        mem_done = 1'b0;
        checks++;
        if ({if_done, if_err, d_done, if_rdata} !== {3'b100, 16'hA5C3}) begin
            errors++;
            $display("FAIL single_done: if_done=%b if_err=%b d_done=%b if_rdata=%h, required 1 0 0 a5c3",
                     if_done, if_err, d_done, if_rdata);
        end
        checks++;
        if (extra_starts !== 0 || early_done !== 0) begin
            errors++;
            $display("FAIL single_wait: extra_starts=%0d early_done=%0d, required 0 0", extra_starts, early_done);
        end
        if_req = 1'b0;
        tick;
        checks++;
        if ({if_done, busy, if_rdata} !== {2'b00, 16'hA5C3}) begin
            errors++;
            $display("FAIL single_after: if_done=%b busy=%b if_rdata=%h, required 0 0 a5c3", if_done, busy, if_rdata);
        end
    endtask

    // Both ports contend every round; exp_fixed selects the expected grant sequence.
    task contend_rounds(input logic exp_fixed, input string name);
        logic exp;
        logic [15:0] exp_addr;
        exp = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if_req = 1'b1; d_req = 1'b1;
            if_addr = 16'h1000 + 16'(r); d_addr = 16'h2000 + 16'(r);
            tick;
            exp_addr = exp ? (16'h2000 + 16'(r)) : (16'h1000 + 16'(r));
            checks++;
            if (grant_id !== exp || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_grant round %0d: grant=%b addr=%h, required %b %h", name, r, grant_id, mem_addr, exp, exp_addr);
            end
            respond(1, 16'hC000 + 16'(r));
            checks++;
            if ({if_done, d_done} !== (exp ? 2'b01 : 2'b10) ||
                (exp ? d_rdata : if_rdata) !== 16'hC000 + 16'(r)) begin
                errors++;
                $display("FAIL %s_done round %0d: if_done=%b d_done=%b if_rdata=%h d_rdata=%h, required port %b data %h",
                         name, r, if_done, d_done, if_rdata, d_rdata, exp, 16'hC000 + 16'(r));
            end
            if (exp) d_req = 1'b0; else if_req = 1'b0;
            tick;
            if (!exp_fixed) exp = ~exp;
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task test_round_robin;
        apply_reset(1'b0);
        contend_rounds(1'b0, "rr");
    endtask

    task test_fixed_priority;
        contend_rounds(1'b1, "fixed");
    endtask

    task test_spurious_and_addr;
        mem_rdata = 16'hFFFF; mem_done = 1'b1;
        tick;
        mem_done = 1'b0; mem_rdata = 16'h0;
        checks++;
        if ({busy, if_done, d_done} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_idle: busy=%b if_done=%b d_done=%b, required 0 0 0", busy, if_done, d_done);
        end
        tick;
        checks++;
        if ({d_done, if_done, d_rdata, if_rdata} !== {2'b00, 16'hC003, 16'hC002}) begin
            errors++;
            $display("FAIL spurious_data: d_done=%b if_done=%b d_rdata=%h if_rdata=%h, required 0 0 c003 c002",
                     d_done, if_done, d_rdata, if_rdata);
        end
        issue(1'b1, 16'h2222, t_st, t_gid, t_ma);
        d_addr = 16'h3333;
        tick; tick;
        checks++;
        if (mem_addr !== 16'h2222 || t_gid !== 1'b1) begin
            errors++;
            $display("FAIL addr_latched: mem_addr=%h gid=%b, required 2222 1", mem_addr, t_gid);
        end
        respond(2, 16'h9999);
        checks++;
        if ({d_done, d_err, d_rdata, mem_addr} !== {2'b10, 16'h9999, 16'h2222}) begin
            errors++;
            $display("FAIL addr_done: d_done=%b d_err=%b d_rdata=%h mem_addr=%h, required 1 0 9999 2222",
                     d_done, d_err, d_rdata, mem_addr);
        end
        d_req = 1'b0;
        tick;
    endtask

    task test_reset_midflight;
        issue(1'b0, 16'h0100, t_st, t_gid, t_ma);
        tick; tick;
        rst_a_n = 1'b0;
        tick;
        test_reset;
        rst_a_n = 1'b1; if_req = 1'b0;
        mem_rdata = 16'h1111; mem_done = 1'b1;
        tick;
        mem_done = 1'b0; mem_rdata = 16'h0;
        checks++;
        if ({busy, if_done, d_done, mem_abort, if_rdata} !== {4'b0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_stray: busy=%b if_done=%b d_done=%b abort=%b if_rdata=%h, required 0 0 0 0 0000",
                     busy, if_done, d_done, mem_abort, if_rdata);
        end
        tick;
        checks++;
        if ({if_done, d_done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_quiet: if_done=%b d_done=%b busy=%b, required 0 0 0", if_done, d_done, busy);
        end
    endtask

    task test_timeout;
        int early_abort;
        early_abort = 0;
        issue(1'b1, 16'h0300, t_st, t_gid, t_ma);
        respond(3, 16'hBEEF);
        checks++;
        if ({d_done, d_err, d_rdata} !== {2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL pre_timeout: d_done=%b d_err=%b d_rdata=%h, required 1 0 beef", d_done, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick;
        issue(1'b1, 16'h1234, t_st, t_gid, t_ma);
        for (int i = 0; i < 15; i++) begin
            if (mem_abort !== 1'b0) early_abort++;
            tick;
        end
        checks++;
        if (mem_abort !== 1'b1 || early_abort !== 0) begin
            errors++;
            $display("FAIL timeout_abort: abort=%b early=%0d, required 1 0 (16 cycles after start)", mem_abort, early_abort);
        end
        tick;
        checks++;
        if ({d_done, d_err, d_rdata, if_done, mem_abort} !== {2'b11, 16'h0000, 2'b00}) begin
            errors++;
            $display("FAIL timeout_resp: d_done=%b d_err=%b d_rdata=%h if_done=%b abort=%b, required 1 1 0000 0 0",
                     d_done, d_err, d_rdata, if_done, mem_abort);
        end
        d_req = 1'b0;
        tick;
        issue(1'b1, 16'h0055, t_st, t_gid, t_ma);
        respond(1, 16'h7E57);
        checks++;
        if ({t_st, t_ma, d_done, d_err, d_rdata} !== {1'b1, 16'h0055, 2'b10, 16'h7E57}) begin
            errors++;
            $display("FAIL post_timeout: start=%b addr=%h d_done=%b d_err=%b d_rdata=%h, required 1 0055 1 0 7e57",
                     t_st, t_ma, d_done, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick;
    endtask

    task test_done_on_timeout;
        issue(1'b0, 16'h0777, t_st, t_gid, t_ma);
        repeat (15) tick;
        checks++;
        if (mem_abort !== 1'b1) begin
            errors++;
            $display("FAIL edge_reached: abort=%b, required 1 on the timeout cycle", mem_abort);
        end
        mem_rdata = 16'h5A5A; mem_done = 1'b1;
        #1;
        checks++;
        if (mem_abort !== 1'b0) begin
            errors++;
            $display("FAIL edge_abort: abort=%b, required 0 when mem_done coincides", mem_abort);
        end
        tick;
        mem_done = 1'b0; mem_rdata = 16'h0;
        checks++;
        if ({if_done, if_err, if_rdata} !== {2'b10, 16'h5A5A}) begin
            errors++;
            $display("FAIL edge_done: if_done=%b if_err=%b if_rdata=%h, required 1 0 5a5a", if_done, if_err, if_rdata);
        end
        if_req = 1'b0;
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(1'b0);
        test_reset;
        test_single_ifetch;
        test_round_robin;
        test_spurious_and_addr;
        test_reset_midflight;
        apply_reset(1'b1);
        test_reset;
        test_fixed_priority;
        test_timeout;
        test_done_on_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
